subtree_response_collector: RTL
===============================

SUBTREE_RESPONSE_COLLECTOR -- requirements
Module: subtree_response_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 16, payload width of every child and parent channel.
REQ-002 SHALL have parameter N_CHILD, default 5, number of child channels; legal range 2..8.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port c_valid  input  N_CHILD  per-child payload valid.
REQ-006 SHALL have port c_data  input  N_CHILD*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port c_ready  output  N_CHILD  per-child accept; at most one bit high per cycle.
REQ-008 SHALL have port p_valid  output  1  parent-side payload valid.
REQ-009 SHALL have port p_data  output  DATA_W  parent-side payload.
REQ-010 SHALL have port p_src  output  3  index of the child that supplied p_data.
REQ-011 SHALL have port p_ready  input  1  parent accept.
REQ-012 SHALL have port xfer_cnt  output  16  count of completed parent-side transfers.

Function
REQ-013 SHALL complete a child transfer on a cycle with c_valid[i] and c_ready[i] both high, and a parent transfer on a cycle with p_valid and p_ready both high.
REQ-014 SHALL hold a round-robin pointer rr_ptr (0..N_CHILD-1); grant goes to the first requesting child at or after rr_ptr, in ascending order with wrap N_CHILD-1 -> 0.
REQ-015 SHALL, after a grant to child g, set rr_ptr to g+1, wrapping to 0 when g = N_CHILD-1; with no grant, rr_ptr is unchanged.
REQ-016 SHALL buffer accepted payloads in a 2-entry FIFO of {src, data}, with registered read/write pointers and an occupancy count of 0..2.
REQ-017 SHALL drive c_ready[g] high only for the granted child and only when occupancy < 2; grant logic is combinational from c_valid, rr_ptr and occupancy.
REQ-018 SHALL drive all c_ready bits low when occupancy = 2, even on a cycle where a parent pop occurs; there is no full-FIFO pass-through.
REQ-019 SHALL drive p_valid = (occupancy != 0), with p_data/p_src taken from the head entry, all from registers.
REQ-020 SHALL present a payload accepted in cycle N on p_valid/p_data in cycle N+1 when the FIFO was empty; minimum latency is 1 cycle.
REQ-021 SHALL, on a simultaneous push and pop, leave occupancy unchanged and preserve order.
REQ-022 SHALL hold p_data/p_src stable while p_valid is high and p_ready is low.
REQ-023 SHALL increment xfer_cnt on each parent transfer, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL leave c_data of non-granted children unsampled; a child dropping c_valid without a transfer loses no state.

Reset
REQ-025 SHALL, while rst_n is low, immediately force occupancy = 0, both FIFO pointers = 0, rr_ptr = 0 and xfer_cnt = 0, giving p_valid = 0 and c_ready = 0.
REQ-026 SHALL discard buffered entries when reset asserts mid-operation; the first grant after release goes to the lowest-index requesting child.
REQ-027 SHALL reset p_data and p_src to 0.

Verification
REQ-028 Bench SHALL cover the single child: child 3 sends 0xA5A5 with p_ready=1 -> c_ready[3] high that cycle; next cycle p_valid=1, p_data=0xA5A5, p_src=3; xfer_cnt=1.
REQ-029 Bench SHALL cover round-robin fairness: all 5 children valid continuously, p_ready=1 -> grant order 0,1,2,3,4,0,1,... with no child granted twice before the others are granted once.
REQ-030 Bench SHALL cover backpressure: p_ready=0 with children 0 and 1 valid -> two entries accepted (src 0, then 1), then all c_ready=0; p_data is held at child 0's value until p_ready=1.
REQ-031 Bench SHALL cover full plus pop: occupancy=2, p_ready=1 for one cycle -> one pop, no push that cycle, occupancy=1; a push occurs the following cycle.
REQ-032 Bench SHALL cover wrap: preload 0xFFFF transfers -> xfer_cnt reads 0x0000 after the next transfer; rr_ptr wraps after a grant to child 4.
REQ-033 Bench SHALL cover reset mid-stream: rst_n low for 1 cycle with occupancy=2 -> p_valid=0 at once; after release, children 2 and 4 valid -> child 2 granted first.

Source files
------------

// File: rtl/subtree_response_collector.sv
// Subtree response collector: round-robin arbiter over N_CHILD valid/ready child
// channels feeding a 2-entry {src, data} FIFO that drives a single parent channel.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   c_valid   per-child payload valid
//   c_data    per-child payload, child i at [i*DATA_W +: DATA_W]
//   c_ready   per-child accept, at most one bit high
//   p_valid   parent payload valid (FIFO not empty)
//   p_data    parent payload (FIFO head)
//   p_src     index of the child that supplied p_data
//   p_ready   parent accept
//   xfer_cnt  completed parent transfers, wraps at 16 bits
module subtree_response_collector #(
  parameter int DATA_W  = 16,
  parameter int N_CHILD = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CHILD-1:0]        c_valid,
  input  logic [N_CHILD*DATA_W-1:0] c_data,
  output logic [N_CHILD-1:0]        c_ready,
  output logic                      p_valid,
  output logic [DATA_W-1:0]         p_data,
  output logic [2:0]                p_src,
  input  logic                      p_ready,
  output logic [15:0]               xfer_cnt
);

  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_data_q [2];
  logic [2:0]        mem_src_q  [2];
  logic [15:0]       xfer_cnt_q;

  logic              grant_vld;
  logic [2:0]        grant_idx;
  logic [3:0]        cand;
  logic              push, pop;
  logic [DATA_W-1:0] push_data;

  // Scan children starting at rr_ptr, wrapping modulo N_CHILD; first requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(N_CHILD)) cand = cand - 4'(N_CHILD);
      if (!grant_vld && c_valid[cand[2:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  // No pass-through when full: a pop in the same cycle does not open a slot.
  // Gated by rst_n so c_ready stays low for the whole reset window.
  assign push = rst_n && grant_vld && (count_q != 2'd2);
  assign pop  = p_valid && p_ready;

  always_comb begin
    c_ready   = '0;
    push_data = '0;
    for (int i = 0; i < N_CHILD; i++) begin
      if (grant_idx == 3'(i)) begin
        c_ready[i] = push;
        push_data  = c_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (grant_idx == 3'(N_CHILD - 1)) ? 3'd0 : grant_idx + 3'd1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      count_q      <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      xfer_cnt_q   <= '0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_src_q[0]  <= '0;
      mem_src_q[1]  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_data_q[wr_ptr_q] <= push_data;
        mem_src_q[wr_ptr_q]  <= grant_idx;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
    end
  end

  assign p_valid  = (count_q != 2'd0);
  assign p_data   = mem_data_q[rd_ptr_q];
  assign p_src    = mem_src_q[rd_ptr_q];
  assign xfer_cnt = xfer_cnt_q;

endmodule
